sap2_control_sequencer: RTL

- Controller-sequencer for the SAP-2 datapath: the initiator of every bus transfer.
- Drives the load and bus-enable strobes that the bus participants (PC, MAR, memory, IR, accumulator, B, C, TMP, ALU, output port) respond to on the shared tri-state 8-bit bus.
- Steps a T-state counter: a fixed 3-state fetch, then an opcode-dependent execute sequence of up to 7 states, plus a terminal HALT.

---
 rtl/sap2_control_sequencer_if.sv | 49 ++++
 rtl/sap2_control_sequencer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/sap2_control_sequencer_if.sv
// SAP-2 controller bundle: datapath status in, bus strobes out.
// The sequencer is the master; the datapath side uses slave.
interface sap2_control_sequencer_if;
  logic       iRun;
  logic [7:0] iOpcode;
  logic       iZero;
  logic       iSign;
  logic       oPcEnable;
  logic       oPcInc;
  logic       oPcLoadLo;
  logic       oPcLoadHi;
  logic       oMarLoad;
  logic       oMemEnable;
  logic       oIrLoad;
  logic       oAccLoad;
  logic       oAccEnable;
  logic       oBLoad;
  logic       oBEnable;
  logic       oCLoad;
  logic       oCEnable;
  logic       oTmpLoad;
  logic       oTmpEnable;
  logic       oAluEnable;
  logic [1:0] oAluOp;
  logic       oFlagLoad;
  logic       oOutLoad;
  logic       oHalt;
  logic [3:0] oTState;

  modport master (
    input  iRun, iOpcode, iZero, iSign,
    output oPcEnable, oPcInc, oPcLoadLo, oPcLoadHi,
    output oMarLoad, oMemEnable, oIrLoad,
    output oAccLoad, oAccEnable, oBLoad, oBEnable,
    output oCLoad, oCEnable, oTmpLoad, oTmpEnable,
    output oAluEnable, oAluOp, oFlagLoad, oOutLoad,
    output oHalt, oTState
  );

  modport slave (
    output iRun, iOpcode, iZero, iSign,
    input  oPcEnable, oPcInc, oPcLoadLo, oPcLoadHi,
    input  oMarLoad, oMemEnable, oIrLoad,
    input  oAccLoad, oAccEnable, oBLoad, oBEnable,
    input  oCLoad, oCEnable, oTmpLoad, oTmpEnable,
    input  oAluEnable, oAluOp, oFlagLoad, oOutLoad,
    input  oHalt, oTState
  );
endinterface

// File: rtl/sap2_control_sequencer.sv
// SAP-2 control sequencer: T-state counter plus Moore strobe decode.
// Fetch T1-T3, opcode-dependent execute T4-T10, terminal HALT.
module sap2_control_sequencer #(
  parameter bit pHaltOnIllegal = 1'b0
) (
  input  logic              iClk,
  input  logic              iReset_n,
  sap2_control_sequencer_if.master bus
);

  typedef enum logic [3:0] {
    S_HALT = 4'd0,
    S_T1   = 4'd1,
    S_T2   = 4'd2,
    S_T3   = 4'd3,
    S_T4   = 4'd4,
    S_T5   = 4'd5,
    S_T6   = 4'd6,
    S_T7   = 4'd7,
    S_T8   = 4'd8,
    S_T9   = 4'd9,
    S_T10  = 4'd10
  } state_t;

  typedef enum logic [3:0] {
    C_NOP, C_MVI, C_MOV, C_ALU, C_OUT,
    C_JMP, C_JCC, C_HLT, C_ILL
  } cls_t;

  state_t r_state;
  state_t w_next;
  logic   r_taken;
  logic   w_taken_next;
  logic   w_cond;
  logic   w_act;
  cls_t   w_cls;
  logic   w_unused;

  assign w_unused = bus.iSign;

  always_comb begin
    w_cls = C_ILL;
    case (bus.iOpcode)
      8'h00:                    w_cls = C_NOP;
      8'h3E, 8'h06, 8'h0E:      w_cls = C_MVI;
      8'h78, 8'h47,
      8'h79, 8'h4F:             w_cls = C_MOV;
      8'h80, 8'h90,
      8'h3C, 8'h3D:             w_cls = C_ALU;
      8'hD3:                    w_cls = C_OUT;
      8'hC3:                    w_cls = C_JMP;
      8'hCA, 8'hC2:             w_cls = C_JCC;
      8'h76:                    w_cls = C_HLT;
      default:                  w_cls = C_ILL;
    endcase
  end

  // JMP is simply a branch whose condition is always true
  assign w_cond = (bus.iOpcode == 8'hC3)
               | ((bus.iOpcode == 8'hCA) & bus.iZero)
               | ((bus.iOpcode == 8'hC2) & ~bus.iZero);

  assign w_act = iReset_n & bus.iRun & (r_state != S_HALT);

  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      r_state <= S_T1;
      r_taken <= 1'b0;
    end else begin
      r_state <= w_next;
      r_taken <= w_taken_next;
    end
  end

  assign bus.oHalt   = (r_state == S_HALT);
  assign bus.oTState = r_state;

  always_comb begin
    bus.oPcEnable  = 1'b0;
    bus.oPcInc     = 1'b0;
    bus.oPcLoadLo  = 1'b0;
    bus.oPcLoadHi  = 1'b0;
    bus.oMarLoad   = 1'b0;
    bus.oMemEnable = 1'b0;
    bus.oIrLoad    = 1'b0;
    bus.oAccLoad   = 1'b0;
    bus.oAccEnable = 1'b0;
    bus.oBLoad     = 1'b0;
    bus.oBEnable   = 1'b0;
    bus.oCLoad     = 1'b0;
    bus.oCEnable   = 1'b0;
    bus.oTmpLoad   = 1'b0;
    bus.oTmpEnable = 1'b0;
    bus.oAluEnable = 1'b0;
    bus.oAluOp     = 2'b00;
    bus.oFlagLoad  = 1'b0;
    bus.oOutLoad   = 1'b0;
    w_next         = r_state;
    w_taken_next   = r_taken;
    if (w_act) begin
      case (r_state)
        S_T1: begin
          bus.oPcEnable = 1'b1;
          bus.oMarLoad  = 1'b1;
          w_next        = S_T2;
        end
        S_T2: begin
          bus.oPcInc = 1'b1;
          w_next     = S_T3;
        end
        S_T3: begin
          bus.oMemEnable = 1'b1;
          bus.oIrLoad    = 1'b1;
          w_next         = S_T4;
        end
        S_T4: begin
          w_next = S_T1;
          case (w_cls)
            C_MVI: begin
              bus.oPcEnable = 1'b1;
              bus.oMarLoad  = 1'b1;
              w_next        = S_T5;
            end
            C_MOV: begin
              bus.oBEnable   = (bus.iOpcode == 8'h78);
              bus.oCEnable   = (bus.iOpcode == 8'h79);
              bus.oAccEnable = (bus.iOpcode == 8'h47)
                             | (bus.iOpcode == 8'h4F);
              bus.oAccLoad   = (bus.iOpcode == 8'h78)
                             | (bus.iOpcode == 8'h79);
              bus.oBLoad     = (bus.iOpcode == 8'h47);
              bus.oCLoad     = (bus.iOpcode == 8'h4F);
            end
            C_ALU: begin
              bus.oAluEnable = 1'b1;
              bus.oAccLoad   = 1'b1;
              bus.oFlagLoad  = 1'b1;
              case (bus.iOpcode)
                8'h90:   bus.oAluOp = 2'b01;
                8'h3C:   bus.oAluOp = 2'b10;
                8'h3D:   bus.oAluOp = 2'b11;
                default: bus.oAluOp = 2'b00;
              endcase
            end
            C_OUT: begin
              bus.oPcInc = 1'b1;
              w_next     = S_T5;
            end
            C_JMP, C_JCC: begin
              w_taken_next  = w_cond;
              bus.oPcEnable = w_cond;
              bus.oMarLoad  = w_cond;
              bus.oPcInc    = ~w_cond;
              w_next        = S_T5;
            end
            C_HLT:   w_next = S_HALT;
            C_ILL:   w_next = pHaltOnIllegal ? S_HALT : S_T1;
            default: w_next = S_T1;
          endcase
        end
        S_T5: begin
          w_next = S_T1;
          case (w_cls)
            C_MVI: begin
              bus.oPcInc = 1'b1;
              w_next     = S_T6;
            end
            C_OUT: begin
              bus.oAccEnable = 1'b1;
              bus.oOutLoad   = 1'b1;
            end
            C_JMP, C_JCC: begin
              bus.oPcInc = 1'b1;
              w_next     = r_taken ? S_T6 : S_T1;
            end
            default: w_next = S_T1;
          endcase
        end
        S_T6: begin
          w_next = S_T1;
          if (w_cls == C_MVI) begin
            bus.oMemEnable = 1'b1;
            bus.oAccLoad   = (bus.iOpcode == 8'h3E);
            bus.oBLoad     = (bus.iOpcode == 8'h06);
            bus.oCLoad     = (bus.iOpcode == 8'h0E);
          end else if (r_taken) begin
            bus.oMemEnable = 1'b1;
            bus.oTmpLoad   = 1'b1;
            w_next         = S_T7;
          end
        end
        S_T7: begin
          bus.oPcEnable = 1'b1;
          bus.oMarLoad  = 1'b1;
          w_next        = S_T8;
        end
        S_T8: begin
          bus.oPcInc = 1'b1;
          w_next     = S_T9;
        end
        S_T9: begin
          bus.oMemEnable = 1'b1;
          bus.oPcLoadHi  = 1'b1;
          w_next         = S_T10;
        end
        S_T10: begin
          bus.oTmpEnable = 1'b1;
          bus.oPcLoadLo  = 1'b1;
          w_next         = S_T1;
        end
        default: w_next = S_T1;
      endcase
    end
  end

endmodule
